axi_rd_wr_master: RTL and testbench
===================================

// Module: axi_rd_wr_master
// PURPOSE
//  AXI4 initiator that turns a single-outstanding CPU memory request (IFU/LSU side) into AXI transactions toward sim_sram-class responders.
//  Reads issue one INCR burst of req_len+1 beats; writes issue one single-beat AW+W pair.
//  Read beats stream back on rsp_*; write completion returns on rsp_* with rsp_last=1.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  64  data width; arsize/awsize = log2(DATA_W/8) = 3'd3
//  ID_W    4   AXI ID width; all IDs driven with AXI_ID
//  AXI_ID  0   constant transaction ID
// PORTS
//  aclk       in   1         clock
//  aresetn    in   1         async active-low reset
//  req_valid/req_ready  in/out  1/1  request handshake
//  req_wen    in   1         1=write, 0=read
//  req_addr   in   ADDR_W    byte address, DATA_W-aligned
//  req_wdata/req_wstrb  in  DATA_W/DATA_W/8  write data/strobe
//  req_len    in   8         read beats-1 (AXI arlen); ignored for writes
//  rsp_valid/rsp_ready  out/in  1/1  response handshake; rsp_ready drives rready/bready
//  rsp_rdata  out  DATA_W    read beat data (0 for write rsp)
//  rsp_last   out  1         final beat of read burst, or write done
//  rsp_err    out  1         rresp/bresp != OKAY (or timeout, see CONFIGURATION)
//  ar{valid,addr,id,len,size,burst}  out  1/ADDR_W/ID_W/8/3/2; arready in 1
//  r{valid,data,id,resp,last} in 1/DATA_W/ID_W/2/1; rready out 1
//  aw{valid,addr,id,len,size,burst}  out  1/ADDR_W/ID_W/8/3/2; awready in 1
//  w{valid,data,strb,last} out 1/DATA_W/DATA_W/8/1; wready in 1
//  b{valid,id,resp} in 1/ID_W/2; bready out 1
//  ar/aw lock,cache,prot  out  tied 0; burst always 2'b01 (INCR); awlen 0; wlast=1
// BEHAVIOUR
//  Reset: FSM=IDLE; arvalid=awvalid=wvalid=0; rready=bready=0; req_ready=0 during reset, 1 in IDLE; rsp_valid=0, rsp_err=0.
//  FSM: IDLE -> AR (req_valid&~req_wen) | AW_W (req_valid&req_wen).
//   AR: arvalid=1, araddr/arlen registered at accept; hold stable until arready -> R.
//   R: rready=rsp_ready; rsp_valid=rvalid, rsp_rdata=rdata, rsp_err=(rresp!=0), rsp_last=rlast (combinational pass-through, zero added latency).
//      Beat counter increments per rvalid&rready; on rlast beat -> IDLE. Counter reaching len with rlast=0: keep accepting; exit only on rlast.
//   AW_W: awvalid and wvalid asserted together in first cycle; each drops independently on its own ready; order of awready/wready arbitrary, same-cycle allowed; both done -> B.
//   B: bready=rsp_ready; rsp_valid=bvalid, rsp_last=1, rsp_err=(bresp!=0); bvalid&bready -> IDLE.
//  req_ready=1 only in IDLE; request captured on req_valid&req_ready; one outstanding txn; next req accepted the cycle after IDLE reentry.
//  Valid never deasserts before its ready (AXI rule); payload stable while valid.
//  rid/bid != AXI_ID: beat still consumed, rsp_err forced 1.
//  Reset asserted mid-transaction: all valids drop immediately (async), FSM=IDLE; no replay.
//  Address not incremented by master; responder computes beat addresses.
// CONFIGURATION
//  AXI_MASTER_TIMEOUT_EN defined: 16-bit cycle counter in AR/R/AW_W/B, cleared on any handshake;
//   at 16'hFFFF: emit one rsp_valid with rsp_err=1, rsp_last=1, rdata=0, drop all valids/readies, -> IDLE.
//  Undefined: no counter; master waits indefinitely.
// TESTING
//  Read len=0 @0x8000_0000, responder returns 0x1122334455667788 OKAY -> one rsp beat, rsp_last=1, rsp_err=0, back to IDLE, req_ready=1.
//  Read len=3 @0x8000_0100, 4 beats D0..D3 with rready backpressure every other cycle -> 4 rsp beats in order, rsp_last only on D3, arlen=3, arsize=3.
//  Write @0x8000_0008 wdata=0xDEADBEEF wstrb=0x0F, wready 3 cycles before awready -> wvalid drops first, awvalid held, one B rsp, rsp_err=0.
//  Write with bresp=2'b10 -> rsp_valid, rsp_last=1, rsp_err=1.
//  aresetn low during R after 2 of 4 beats -> arvalid/rready/rsp_valid=0 same cycle, req_ready=1 after release.
//  AXI_MASTER_TIMEOUT_EN: arready held 0 for 65536 cycles -> single rsp_err=1 beat, arvalid drops, FSM IDLE.

Source files
------------

// File: rtl/axi_rd_wr_master_if.sv
// CPU request/response channel plus AXI4 read/write bus bundle.
interface axi_rd_wr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic [7:0]        req_len;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              rsp_err;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;

  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;

  modport master (
    input  req_valid, req_wen, req_addr,
    input  req_wdata, req_wstrb, req_len,
    output req_ready,
    output rsp_valid, rsp_rdata,
    output rsp_last, rsp_err,
    input  rsp_ready,
    output arvalid, araddr, arid, arlen,
    output arsize, arburst, arlock,
    output arcache, arprot,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen,
    output awsize, awburst, awlock,
    output awcache, awprot,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    output req_valid, req_wen, req_addr,
    output req_wdata, req_wstrb, req_len,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_last, rsp_err,
    output rsp_ready,
    input  arvalid, araddr, arid, arlen,
    input  arsize, arburst, arlock,
    input  arcache, arprot,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen,
    input  awsize, awburst, awlock,
    input  awcache, awprot,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_rd_wr_master.sv
// Single-outstanding CPU request to AXI4 read burst / single write.
// Optional watchdog: define AXI_MASTER_TIMEOUT_EN.
module axi_rd_wr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int AXI_ID = 0
) (
  input logic aclk,
  input logic aresetn,
  axi_rd_wr_master_if.master bus
);

  localparam logic [ID_W-1:0] L_ID = ID_W'(AXI_ID);
  localparam logic [2:0] L_SIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_TO
  } state_t;

  state_t r_state, r_state_n;

  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_aw_done, r_aw_done_n;
  logic                r_w_done, r_w_done_n;
  logic [7:0]          r_beat, r_beat_n;
  logic                w_accept;
  logic                w_to_hit;
  logic                w_hs;

  assign w_hs = (bus.arvalid & bus.arready)
              | (bus.rvalid  & bus.rready)
              | (bus.awvalid & bus.awready)
              | (bus.wvalid  & bus.wready)
              | (bus.bvalid  & bus.bready);

`ifdef AXI_MASTER_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        w_busy;

  assign w_busy = (r_state == S_AR) | (r_state == S_R)
                | (r_state == S_AW_W) | (r_state == S_B);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      r_to_cnt <= '0;
    else if (!w_busy || w_hs)
      r_to_cnt <= '0;
    else
      r_to_cnt <= r_to_cnt + 16'd1;
  end

  assign w_to_hit = w_busy & (r_to_cnt == 16'hFFFF);
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    r_state_n   = r_state;
    r_aw_done_n = r_aw_done;
    r_w_done_n  = r_w_done;
    r_beat_n    = r_beat;
    w_accept    = 1'b0;

    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_last  = 1'b0;
    bus.rsp_err   = 1'b0;

    bus.arvalid = 1'b0;
    bus.araddr  = r_addr;
    bus.arid    = L_ID;
    bus.arlen   = r_len;
    bus.arsize  = L_SIZE;
    bus.arburst = 2'b01;
    bus.arlock  = 1'b0;
    bus.arcache = 4'd0;
    bus.arprot  = 3'd0;
    bus.rready  = 1'b0;

    bus.awvalid = 1'b0;
    bus.awaddr  = r_addr;
    bus.awid    = L_ID;
    bus.awlen   = 8'd0;
    bus.awsize  = L_SIZE;
    bus.awburst = 2'b01;
    bus.awlock  = 1'b0;
    bus.awcache = 4'd0;
    bus.awprot  = 3'd0;
    bus.wvalid  = 1'b0;
    bus.wdata   = r_wdata;
    bus.wstrb   = r_wstrb;
    bus.wlast   = 1'b1;
    bus.bready  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = aresetn;
        if (bus.req_valid && aresetn) begin
          w_accept    = 1'b1;
          r_aw_done_n = 1'b0;
          r_w_done_n  = 1'b0;
          r_beat_n    = 8'd0;
          r_state_n   = bus.req_wen ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready)
          r_state_n = S_R;
      end
      S_R: begin
        bus.rready    = bus.rsp_ready;
        bus.rsp_valid = bus.rvalid;
        bus.rsp_rdata = bus.rdata;
        bus.rsp_last  = bus.rlast;
        bus.rsp_err   = (bus.rresp != 2'b00)
                      | (bus.rid != L_ID);
        // rlast alone ends the burst, the count is advisory
        if (bus.rvalid && bus.rsp_ready) begin
          r_beat_n = r_beat + 8'd1;
          if (bus.rlast)
            r_state_n = S_IDLE;
        end
      end
      S_AW_W: begin
        bus.awvalid = ~r_aw_done;
        bus.wvalid  = ~r_w_done;
        r_aw_done_n = r_aw_done | bus.awready;
        r_w_done_n  = r_w_done | bus.wready;
        if (r_aw_done_n && r_w_done_n)
          r_state_n = S_B;
      end
      S_B: begin
        bus.bready    = bus.rsp_ready;
        bus.rsp_valid = bus.bvalid;
        bus.rsp_last  = 1'b1;
        bus.rsp_err   = (bus.bresp != 2'b00)
                      | (bus.bid != L_ID);
        if (bus.bvalid && bus.rsp_ready)
          r_state_n = S_IDLE;
      end
      S_TO: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_last  = 1'b1;
        bus.rsp_err   = 1'b1;
        if (bus.rsp_ready)
          r_state_n = S_IDLE;
      end
      default: r_state_n = S_IDLE;
    endcase

    // watchdog expiry abandons the bus so no late handshake slips in
    if (w_to_hit) begin
      bus.arvalid   = 1'b0;
      bus.rready    = 1'b0;
      bus.awvalid   = 1'b0;
      bus.wvalid    = 1'b0;
      bus.bready    = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_last  = 1'b0;
      bus.rsp_err   = 1'b0;
      r_state_n     = S_TO;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_beat    <= 8'd0;
    end else begin
      r_state   <= r_state_n;
      r_aw_done <= r_aw_done_n;
      r_w_done  <= r_w_done_n;
      r_beat    <= r_beat_n;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_accept) begin
      r_addr  <= bus.req_addr;
      r_len   <= bus.req_wen ? 8'd0 : bus.req_len;
      r_wdata <= bus.req_wdata;
      r_wstrb <= bus.req_wstrb;
    end
  end

endmodule

// File: tb/tb_axi_rd_wr_master.sv
// Scoreboard bench for axi_rd_wr_master.
// Timeout case runs when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi_rd_wr_master;

  logic aclk;
  logic aresetn;

  axi_rd_wr_master_if #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4)
  ) bus ();

  axi_rd_wr_master #(
    .ADDR_W(32), .DATA_W(64),
    .ID_W(4), .AXI_ID(0)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, req);
    end
  endtask

  // rsp handshake completes at the following posedge
  initial begin
    rsp_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected actual=%h required=none",
                   bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_rdata !== e.data ||
              bus.rsp_last !== e.last ||
              bus.rsp_err !== e.err) begin
            failures++;
            $display("FAIL rsp actual=%h/%b/%b required=%h/%b/%b",
                     bus.rsp_rdata, bus.rsp_last, bus.rsp_err,
                     e.data, e.last, e.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue(input logic wen,
                       input logic [31:0] addr,
                       input logic [7:0] len,
                       input logic [63:0] wd,
                       input logic [7:0] ws);
    int n;
    bus.req_valid = 1'b1;
    bus.req_wen   = wen;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    n = 0;
    #1;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("req_timeout", 0, 1);
    tick();
    bus.req_valid = 1'b0;
    #1;
  endtask

  function automatic rsp_t mk(input logic [63:0] d,
                              input logic l,
                              input logic e);
    rsp_t r;
    r.data = d;
    r.last = l;
    r.err  = e;
    return r;
  endfunction

  initial begin
    logic [63:0] d [4];
    int i;
    int cyc;
    logic hs;

    d[0] = 64'hD0D0_0000_0000_0000;
    d[1] = 64'hD1D1_1111_1111_1111;
    d[2] = 64'hD2D2_2222_2222_2222;
    d[3] = 64'hD3D3_3333_3333_3333;

    aresetn = 1'b0;
    bus.req_valid = 0; bus.req_wen = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_wstrb = 0; bus.req_len = 0;
    bus.rsp_ready = 1;
    bus.arready = 0; bus.awready = 0; bus.wready = 0;
    bus.rvalid = 0; bus.rdata = 0; bus.rid = 0;
    bus.rresp = 0; bus.rlast = 0;
    bus.bvalid = 0; bus.bid = 0; bus.bresp = 0;

    #3;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    #20;
    aresetn = 1'b1;
    tick();
    chk("idle_req_ready", bus.req_ready, 1);

    // read, single beat
    issue(0, 32'h8000_0000, 8'd0, 0, 0);
    chk("r1_arvalid", bus.arvalid, 1);
    chk("r1_araddr", bus.araddr, 64'h8000_0000);
    chk("r1_arlen", bus.arlen, 0);
    chk("r1_arburst", bus.arburst, 1);
    bus.arready = 1;
    tick();
    bus.arready = 0;
    exp_q.push_back(mk(64'h1122334455667788, 1, 0));
    bus.rvalid = 1; bus.rdata = 64'h1122334455667788;
    bus.rlast = 1; bus.rresp = 0;
    tick();
    bus.rvalid = 0; bus.rlast = 0;
    #1;
    chk("r1_req_ready", bus.req_ready, 1);

    // read burst with rsp_ready backpressure
    issue(0, 32'h8000_0100, 8'd3, 0, 0);
    chk("r4_arlen", bus.arlen, 3);
    chk("r4_arsize", bus.arsize, 3);
    tick();
    tick();
    chk("r4_arvalid_hold", bus.arvalid, 1);
    chk("r4_araddr_hold", bus.araddr, 64'h8000_0100);
    bus.arready = 1;
    tick();
    bus.arready = 0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(d[k], k == 3, 0));
    i = 0;
    cyc = 0;
    while (i < 4 && cyc < 50) begin
      bus.rvalid = 1;
      bus.rdata = d[i];
      bus.rlast = (i == 3);
      bus.rsp_ready = cyc[0];
      hs = cyc[0];
      #1;
      if (cyc == 1) chk("r4_rready", bus.rready, 1);
      if (cyc == 2) chk("r4_rready_bp", bus.rready, 0);
      tick();
      if (hs) i++;
      cyc++;
    end
    chk("r4_beats", i, 4);
    bus.rvalid = 0; bus.rlast = 0; bus.rsp_ready = 1;
    #1;
    chk("r4_req_ready", bus.req_ready, 1);

    // read with wrong rid
    issue(0, 32'h8000_0200, 8'd0, 0, 0);
    bus.arready = 1;
    tick();
    bus.arready = 0;
    exp_q.push_back(mk(64'h55, 1, 1));
    bus.rvalid = 1; bus.rdata = 64'h55;
    bus.rlast = 1; bus.rid = 4'd5;
    tick();
    bus.rvalid = 0; bus.rlast = 0; bus.rid = 0;

    // write, wready ahead of awready
    issue(1, 32'h8000_0008, 0, 64'hDEADBEEF, 8'h0F);
    chk("w1_awvalid", bus.awvalid, 1);
    chk("w1_wvalid", bus.wvalid, 1);
    chk("w1_awaddr", bus.awaddr, 64'h8000_0008);
    chk("w1_wdata", bus.wdata, 64'hDEADBEEF);
    chk("w1_wstrb", bus.wstrb, 8'h0F);
    chk("w1_wlast", bus.wlast, 1);
    chk("w1_awlen", bus.awlen, 0);
    bus.wready = 1;
    tick();
    bus.wready = 0;
    #1;
    chk("w1_wvalid_drop", bus.wvalid, 0);
    chk("w1_awvalid_hold", bus.awvalid, 1);
    tick();
    tick();
    chk("w1_awvalid_hold3", bus.awvalid, 1);
    bus.awready = 1;
    tick();
    bus.awready = 0;
    #1;
    chk("w1_bready", bus.bready, 1);
    exp_q.push_back(mk(0, 1, 0));
    bus.bvalid = 1; bus.bresp = 0;
    tick();
    bus.bvalid = 0;
    #1;
    chk("w1_req_ready", bus.req_ready, 1);

    // write with SLVERR, same-cycle aw/w
    issue(1, 32'h8000_0010, 0, 64'h1234, 8'hFF);
    bus.awready = 1; bus.wready = 1;
    tick();
    bus.awready = 0; bus.wready = 0;
    exp_q.push_back(mk(0, 1, 1));
    bus.bvalid = 1; bus.bresp = 2'b10;
    tick();
    bus.bvalid = 0; bus.bresp = 0;

    // reset in the middle of a burst
    issue(0, 32'h8000_0300, 8'd3, 0, 0);
    bus.arready = 1;
    tick();
    bus.arready = 0;
    exp_q.push_back(mk(d[0], 0, 0));
    exp_q.push_back(mk(d[1], 0, 0));
    for (int k = 0; k < 2; k++) begin
      bus.rvalid = 1; bus.rdata = d[k]; bus.rlast = 0;
      tick();
    end
    bus.rvalid = 1; bus.rdata = d[2];
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_arvalid", bus.arvalid, 0);
    chk("rst_mid_rready", bus.rready, 0);
    chk("rst_mid_rsp_valid", bus.rsp_valid, 0);
    bus.rvalid = 0;
    tick();
    #2;
    aresetn = 1'b1;
    #1;
    chk("rst_mid_req_ready", bus.req_ready, 1);
    tick();

`ifdef AXI_MASTER_TIMEOUT_EN
    issue(0, 32'h8000_0400, 8'd0, 0, 0);
    exp_q.push_back(mk(0, 1, 1));
    cyc = 0;
    while (!bus.req_ready && cyc < 70000) begin
      tick();
      cyc++;
    end
    chk("to_idle", bus.req_ready, 1);
    chk("to_arvalid", bus.arvalid, 0);
`endif

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
